// File: rtl/program_loader_pkg.sv
// loader_defs: shared state encoding and framing constants for program_loader.
// PROGRAM_LOADER_CHECKSUM_EN adds the S_CHECK state.
package loader_defs;
  localparam logic [7:0] LOAD_CMD_DEFAULT = 8'h4C;
  localparam int BYTES_PER_WORD = 2;
  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_WORD_HI, S_WORD_LO, S_WRITE, S_DONE
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;
endpackage

// File: rtl/program_loader.sv
// program_loader: frames UART bytes into instruction words and writes them to program memory.
// PROGRAM_LOADER_CHECKSUM_EN appends an XOR checksum byte that must match before loadDone.
module program_loader
  import loader_defs::*;
#(
  parameter int ADDR_LENGTH = 11,
  parameter int DATA_LENGTH = 8 * BYTES_PER_WORD,
  parameter logic [7:0] LOAD_CMD = LOAD_CMD_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rxData,
  input  logic                   rxDone,
  output logic                   Wr,
  output logic [ADDR_LENGTH-1:0] addrToMem,
  output logic [DATA_LENGTH-1:0] dataToMem,
  output logic                   bipHold,
  output logic                   loadDone,
  output logic                   loadError
);
  state_t r_state, w_next;
  logic [7:0] r_cnt_hi;
  logic [ADDR_LENGTH:0] r_rem;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [DATA_LENGTH-1:0] r_data;
  logic r_err;
  logic [31:0] w_cnt;
  logic w_cnt_bad, w_last, w_start;
  assign w_cnt = {16'd0, r_cnt_hi, rxData};
  assign w_cnt_bad = w_cnt > (32'd1 << ADDR_LENGTH);
  assign w_last = r_rem == {{ADDR_LENGTH{1'b0}}, 1'b1};
  assign w_start = r_state == S_IDLE && rxDone && rxData == LOAD_CMD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t TAIL = S_CHECK;
  logic [7:0] r_xor;
  logic w_ck_bad;
  assign w_ck_bad = r_state == S_CHECK && rxDone && rxData != r_xor;
`else
  localparam state_t TAIL = S_DONE;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_CNT_HI;
      S_CNT_HI:  if (rxDone) w_next = S_CNT_LO;
      S_CNT_LO:  if (rxDone) w_next = w_cnt == '0 ? TAIL : w_cnt_bad ? S_IDLE : S_WORD_HI;
      S_WORD_HI: if (rxDone) w_next = S_WORD_LO;
      S_WORD_LO: if (rxDone) w_next = S_WRITE;
      S_WRITE:   w_next = w_last ? TAIL : S_WORD_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK:   if (rxDone) w_next = w_ck_bad ? S_IDLE : S_DONE;
`endif
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt_hi <= '0;
      r_rem    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_err    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_xor    <= '0;
`endif
    end else begin
      if (w_start) begin
        r_err  <= 1'b0;
        r_addr <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        r_xor  <= '0;
`endif
      end
      if (rxDone && r_state == S_CNT_HI) r_cnt_hi <= rxData;
      if (rxDone && r_state == S_CNT_LO) begin
        r_rem <= w_cnt[ADDR_LENGTH:0];
        if (w_cnt_bad) r_err <= 1'b1;
      end
      if (rxDone && r_state == S_WORD_HI) r_data[DATA_LENGTH-1 -: 8] <= rxData;
      if (rxDone && r_state == S_WORD_LO) r_data[7:0] <= rxData;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (rxDone && (r_state == S_WORD_HI || r_state == S_WORD_LO)) r_xor <= r_xor ^ rxData;
      if (w_ck_bad) r_err <= 1'b1;
`endif
      if (r_state == S_WRITE) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end
      // bytes landing in the non-receiving states are lost, so flag the load as suspect
      if (rxDone && (r_state == S_WRITE || r_state == S_DONE)) r_err <= 1'b1;
    end
  assign Wr        = r_state == S_WRITE;
  assign addrToMem = r_addr;
  assign dataToMem = r_data;
  assign bipHold   = r_state != S_IDLE;
  assign loadDone  = r_state == S_DONE;
  assign loadError = r_err;
endmodule
